fpu_compare_pipe: RTL and testbench

Pipelined, parametrised floating-point compare and min/max unit for the FPU arithmetic cluster. It replaces the single-precision combinational comparator with a format-generic block. The block takes full IEEE-754 encodings, classifies NaNs internally and executes FEQ/FLT/FLE/FMIN/FMAX. It has a two-stage valid/ready pipeline with flush, one result per cycle at full throughput.

---
 rtl/fpu_compare_pipe.sv | 270 +++++++++++++++++++++++++++
 tb/tb_fpu_compare_pipe.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_compare_pipe.sv
// fpu_compare_pipe: two-stage floating-point compare / min-max unit.
// Stage 1 classifies both operands (NaN, sNaN, zero) and does the unsigned
// magnitude compare of {exp,mant}; stage 2 applies sign and NaN rules and
// registers the result. A valid/ready handshake provides full throughput,
// pass-through ready and a synchronous flush.
// Optional feature macro: FPU_CMP_MINMAX_EN. When defined, FMIN/FMAX are
// implemented. Otherwise op codes 011/100 report illegal_o.
module fpu_compare_pipe #(
    parameter int  EXP_W = 8,
    parameter int  MAN_W = 23,
    localparam int FLEN  = 1 + EXP_W + MAN_W
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [2:0]      op_i,
    input  logic [FLEN-1:0] a_i,
    input  logic [FLEN-1:0] b_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [FLEN-1:0] result_o,
    output logic            nv_o,
    output logic            illegal_o
);

    localparam logic [2:0] OP_FLE  = 3'b000;
    localparam logic [2:0] OP_FLT  = 3'b001;
    localparam logic [2:0] OP_FEQ  = 3'b010;
    localparam logic [2:0] OP_FMIN = 3'b011;
    localparam logic [2:0] OP_FMAX = 3'b100;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic s1_valid_q, s1_valid_d;
    logic out_valid_q, out_valid_d;
    logic s2_adv;
    logic s1_adv;
    logic in_fire;

    assign s2_adv     = !out_valid_q || out_ready_i;
    assign s1_adv     = !s1_valid_q || s2_adv;
    // Flush also blocks capture of a same-cycle input.
    assign in_ready_o = s1_adv && !flush_i;
    assign in_fire    = in_valid_i && in_ready_o;

    // ------------------------------------------------------------------
    // Stage 1: operand classification and magnitude compare
    // ------------------------------------------------------------------
    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_man, b_man;
    logic [2:0]       a_cls, b_cls;     // {nan, snan, zero}
    logic             mag_lt, mag_eq;

    assign a_exp = a_i[FLEN-2 -: EXP_W];
    assign b_exp = b_i[FLEN-2 -: EXP_W];
    assign a_man = a_i[MAN_W-1:0];
    assign b_man = b_i[MAN_W-1:0];

    assign a_cls[2] = (&a_exp) && (|a_man);
    assign a_cls[1] = a_cls[2] && !a_man[MAN_W-1];
    assign a_cls[0] = ~|a_i[FLEN-2:0];
    assign b_cls[2] = (&b_exp) && (|b_man);
    assign b_cls[1] = b_cls[2] && !b_man[MAN_W-1];
    assign b_cls[0] = ~|b_i[FLEN-2:0];

    // Unsigned compare of {exp,mant} gives IEEE magnitude order directly.
    assign mag_lt = a_i[FLEN-2:0] < b_i[FLEN-2:0];
    assign mag_eq = a_i[FLEN-2:0] == b_i[FLEN-2:0];

    logic [2:0] s1_op_q, s1_op_d;
    logic [2:0] s1_a_cls_q, s1_a_cls_d;
    logic [2:0] s1_b_cls_q, s1_b_cls_d;
    logic       s1_a_sign_q, s1_a_sign_d;
    logic       s1_b_sign_q, s1_b_sign_d;
    logic       s1_mag_lt_q, s1_mag_lt_d;
    logic       s1_mag_eq_q, s1_mag_eq_d;
`ifdef FPU_CMP_MINMAX_EN
    logic [FLEN-1:0] s1_a_q, s1_a_d;
    logic [FLEN-1:0] s1_b_q, s1_b_d;
`endif

    // Stage-1 next state: load on an accepted input, hold otherwise.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_op_d     = s1_op_q;
        s1_a_cls_d  = s1_a_cls_q;
        s1_b_cls_d  = s1_b_cls_q;
        s1_a_sign_d = s1_a_sign_q;
        s1_b_sign_d = s1_b_sign_q;
        s1_mag_lt_d = s1_mag_lt_q;
        s1_mag_eq_d = s1_mag_eq_q;
`ifdef FPU_CMP_MINMAX_EN
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
`endif
        if (flush_i) begin
            s1_valid_d = 1'b0;
        end else if (s1_adv) begin
            s1_valid_d = in_valid_i;
        end
        if (in_fire) begin
            s1_op_d     = op_i;
            s1_a_cls_d  = a_cls;
            s1_b_cls_d  = b_cls;
            s1_a_sign_d = a_i[FLEN-1];
            s1_b_sign_d = b_i[FLEN-1];
            s1_mag_lt_d = mag_lt;
            s1_mag_eq_d = mag_eq;
`ifdef FPU_CMP_MINMAX_EN
            s1_a_d      = a_i;
            s1_b_d      = b_i;
`endif
        end
    end

    // Stage-1 registers.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= '0;
            s1_a_cls_q  <= '0;
            s1_b_cls_q  <= '0;
            s1_a_sign_q <= 1'b0;
            s1_b_sign_q <= 1'b0;
            s1_mag_lt_q <= 1'b0;
            s1_mag_eq_q <= 1'b0;
`ifdef FPU_CMP_MINMAX_EN
            s1_a_q      <= '0;
            s1_b_q      <= '0;
`endif
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_a_cls_q  <= s1_a_cls_d;
            s1_b_cls_q  <= s1_b_cls_d;
            s1_a_sign_q <= s1_a_sign_d;
            s1_b_sign_q <= s1_b_sign_d;
            s1_mag_lt_q <= s1_mag_lt_d;
            s1_mag_eq_q <= s1_mag_eq_d;
`ifdef FPU_CMP_MINMAX_EN
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: sign / NaN resolution
    // ------------------------------------------------------------------
    logic            any_nan, any_snan, both_zero;
    logic            eq_c, lt_c;
    logic [FLEN-1:0] res_c;
    logic            nv_c, ill_c;
`ifdef FPU_CMP_MINMAX_EN
    localparam logic [FLEN-1:0] CANON_NAN =
        {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    logic            a_below_b;
`endif

    // Ordering relation between the stage-1 operands (NaNs handled later).
    always_comb begin
        any_nan   = s1_a_cls_q[2] || s1_b_cls_q[2];
        any_snan  = s1_a_cls_q[1] || s1_b_cls_q[1];
        both_zero = s1_a_cls_q[0] && s1_b_cls_q[0];
        eq_c      = both_zero || (s1_mag_eq_q && (s1_a_sign_q == s1_b_sign_q));
        if (both_zero) begin
            lt_c = 1'b0;
        end else if (s1_a_sign_q != s1_b_sign_q) begin
            lt_c = s1_a_sign_q;
        end else if (s1_a_sign_q) begin
            lt_c = !s1_mag_lt_q && !s1_mag_eq_q;
        end else begin
            lt_c = s1_mag_lt_q;
        end
`ifdef FPU_CMP_MINMAX_EN
        // Min/max distinguishes signed zeros: -0 orders below +0.
        a_below_b = both_zero ? (s1_a_sign_q && !s1_b_sign_q) : lt_c;
`endif
    end

    // Per-op result, invalid flag and illegal-op detection.
    always_comb begin
        res_c = '0;
        nv_c  = 1'b0;
        ill_c = 1'b0;
        case (s1_op_q)
            OP_FLE: begin
                res_c[0] = !any_nan && (lt_c || eq_c);
                nv_c     = any_nan;
            end
            OP_FLT: begin
                res_c[0] = !any_nan && lt_c;
                nv_c     = any_nan;
            end
            OP_FEQ: begin
                res_c[0] = !any_nan && eq_c;
                nv_c     = any_snan;
            end
`ifdef FPU_CMP_MINMAX_EN
            OP_FMIN, OP_FMAX: begin
                if (s1_a_cls_q[2] && s1_b_cls_q[2]) begin
                    res_c = CANON_NAN;
                end else if (s1_a_cls_q[2]) begin
                    res_c = s1_b_q;
                end else if (s1_b_cls_q[2]) begin
                    res_c = s1_a_q;
                end else if (s1_op_q == OP_FMIN) begin
                    res_c = a_below_b ? s1_a_q : s1_b_q;
                end else begin
                    res_c = a_below_b ? s1_b_q : s1_a_q;
                end
                nv_c = any_snan;
            end
`else
            OP_FMIN, OP_FMAX: begin
                ill_c = 1'b1;
            end
`endif
            default: begin
                ill_c = 1'b1;
            end
        endcase
    end

    logic [FLEN-1:0] result_q, result_d;
    logic            nv_q, nv_d;
    logic            illegal_q, illegal_d;

    // Stage-2 next state: outputs hold while stalled.
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        nv_d        = nv_q;
        illegal_d   = illegal_q;
        if (flush_i) begin
            out_valid_d = 1'b0;
        end else if (s2_adv) begin
            out_valid_d = s1_valid_q;
        end
        if (s2_adv && s1_valid_q && !flush_i) begin
            result_d  = res_c;
            nv_d      = nv_c;
            illegal_d = ill_c;
        end
    end

    // Stage-2 registers.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            nv_q        <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            nv_q        <= nv_d;
            illegal_q   <= illegal_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign result_o    = result_q;
    assign nv_o        = nv_q;
    assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_fpu_compare_pipe.sv
// Directed testbench for fpu_compare_pipe: a single-precision instance and a
// double-precision instance run in lockstep on shared control signals.
module tb_fpu_compare_pipe;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [2:0]  op;
    logic        out_ready;
    logic [31:0] a32, b32;
    logic [63:0] a64, b64;
    logic        in_ready32, in_ready64;
    logic        out_valid32, out_valid64;
    logic [31:0] res32;
    logic [63:0] res64;
    logic        nv32, nv64, ill32, ill64;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        nv;
        logic        ill;
    } vec_t;

    fpu_compare_pipe #(.EXP_W(8), .MAN_W(23)) dut32 (
        .clk_i(clk), .reset_i(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready32), .op_i(op),
        .a_i(a32), .b_i(b32), .out_valid_o(out_valid32),
        .out_ready_i(out_ready), .result_o(res32), .nv_o(nv32),
        .illegal_o(ill32)
    );

    fpu_compare_pipe #(.EXP_W(11), .MAN_W(52)) dut64 (
        .clk_i(clk), .reset_i(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready64), .op_i(op),
        .a_i(a64), .b_i(b64), .out_valid_o(out_valid64),
        .out_ready_i(out_ready), .result_o(res64), .nv_o(nv64),
        .illegal_o(ill64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op to both DUTs and wait (bounded) for the 32-bit result.
    task automatic run_op(input logic [2:0] o, input logic [63:0] a,
                          input logic [63:0] b,
                          output logic [31:0] r32, output logic [1:0] f32,
                          output logic [63:0] r64, output logic [1:0] f64,
                          output int lat);
        @(negedge clk);
        op = o; a32 = a[31:0]; b32 = b[31:0]; a64 = a; b64 = b;
        in_valid = 1'b1; out_ready = 1'b1;
        lat = 0; r32 = 'x; f32 = 'x; r64 = 'x; f64 = 'x;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            if (out_valid32) begin
                lat = c; r32 = res32; f32 = {nv32, ill32};
                if (out_valid64) begin
                    r64 = res64; f64 = {nv64, ill64};
                end
                break;
            end
        end
        $display("op=%03b a=%h b=%h -> r32=%h nv/ill=%b r64=%h lat=%0d",
                 o, a, b, r32, f32, r64, lat);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = 3'b000; a32 = '0; b32 = '0; a64 = '0; b64 = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_cnt++;
        if ({out_valid32, res32, nv32, ill32} !== 35'd0) $display("FAIL reset_out32: got %h want 0", {out_valid32, res32, nv32, ill32});
        else pass_cnt++;
        chk_cnt++;
        if ({out_valid64, res64, nv64, ill64} !== 67'd0) $display("FAIL reset_out64: got %h want 0", {out_valid64, res64, nv64, ill64});
        else pass_cnt++;
        chk_cnt++;
        if ({in_ready32, in_ready64} !== 2'b11) $display("FAIL reset_in_ready: got %b want 11", {in_ready32, in_ready64});
        else pass_cnt++;
    endtask

    task automatic run_table(input string name, input vec_t tab[], input int n);
        logic [31:0] r32; logic [1:0] f32; logic [63:0] r64; logic [1:0] f64;
        int lat;
        for (int i = 0; i < n; i++) begin
            run_op(tab[i].op, {32'h0, tab[i].a}, {32'h0, tab[i].b}, r32, f32, r64, f64, lat);
            chk_cnt++;
            if ({r32, f32} !== {tab[i].r, tab[i].nv, tab[i].ill} || lat != 2)
                $display("FAIL %s[%0d]: got r=%h nv/ill=%b lat=%0d want r=%h nv/ill=%b lat=2",
                         name, i, r32, f32, lat, tab[i].r, {tab[i].nv, tab[i].ill});
            else pass_cnt++;
        end
    endtask

    task automatic test_compare();
        vec_t t[] = new[10];
        t[0] = {3'b001, 32'hBF800000, 32'h3F800000, 32'h1, 1'b0, 1'b0};
        t[1] = {3'b000, 32'h80000000, 32'h00000000, 32'h1, 1'b0, 1'b0};
        t[2] = {3'b010, 32'h80000000, 32'h00000000, 32'h1, 1'b0, 1'b0};
        t[3] = {3'b001, 32'h3F800000, 32'hBF800000, 32'h0, 1'b0, 1'b0};
        t[4] = {3'b001, 32'hC0000000, 32'hBF800000, 32'h1, 1'b0, 1'b0};
        t[5] = {3'b000, 32'hBF800000, 32'hC0000000, 32'h0, 1'b0, 1'b0};
        t[6] = {3'b010, 32'h3F800000, 32'h3F800000, 32'h1, 1'b0, 1'b0};
        t[7] = {3'b001, 32'h80000000, 32'h00000000, 32'h0, 1'b0, 1'b0};
        t[8] = {3'b000, 32'h00000000, 32'h3F800000, 32'h1, 1'b0, 1'b0};
        t[9] = {3'b001, 32'h3F800000, 32'h7F800000, 32'h1, 1'b0, 1'b0};
        run_table("compare", t, 10);
    endtask

    task automatic test_nan();
        vec_t t[] = new[5];
        t[0] = {3'b010, 32'h7FA00000, 32'h3F800000, 32'h0, 1'b1, 1'b0};
        t[1] = {3'b010, 32'h7FC00000, 32'h3F800000, 32'h0, 1'b0, 1'b0};
        t[2] = {3'b001, 32'h7FC00000, 32'h3F800000, 32'h0, 1'b1, 1'b0};
        t[3] = {3'b000, 32'h3F800000, 32'h7FA00000, 32'h0, 1'b1, 1'b0};
        t[4] = {3'b010, 32'h7FC00000, 32'h7FC00000, 32'h0, 1'b0, 1'b0};
        run_table("nan", t, 5);
    endtask

    task automatic test_minmax();
`ifdef FPU_CMP_MINMAX_EN
        vec_t t[] = new[8];
        t[0] = {3'b011, 32'h7FC00000, 32'h40000000, 32'h40000000, 1'b0, 1'b0};
        t[1] = {3'b100, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 1'b0, 1'b0};
        t[2] = {3'b011, 32'h00000000, 32'h80000000, 32'h80000000, 1'b0, 1'b0};
        t[3] = {3'b100, 32'h00000000, 32'h80000000, 32'h00000000, 1'b0, 1'b0};
        t[4] = {3'b011, 32'h7FA00000, 32'h3F800000, 32'h3F800000, 1'b1, 1'b0};
        t[5] = {3'b100, 32'hBF800000, 32'hC0000000, 32'hBF800000, 1'b0, 1'b0};
        t[6] = {3'b011, 32'h7FA00000, 32'h7FC00000, 32'h7FC00000, 1'b1, 1'b0};
        t[7] = {3'b100, 32'h7FC00001, 32'hFFC00000, 32'h7FC00000, 1'b0, 1'b0};
        run_table("minmax", t, 8);
`else
        vec_t t[] = new[2];
        t[0] = {3'b011, 32'h7FC00000, 32'h40000000, 32'h0, 1'b0, 1'b1};
        t[1] = {3'b100, 32'h00000000, 32'h80000000, 32'h0, 1'b0, 1'b1};
        run_table("minmax_off", t, 2);
`endif
    endtask

    task automatic test_illegal();
        vec_t t[] = new[2];
        t[0] = {3'b101, 32'h3F800000, 32'h40000000, 32'h0, 1'b0, 1'b1};
        t[1] = {3'b111, 32'hBF800000, 32'h3F800000, 32'h0, 1'b0, 1'b1};
        run_table("illegal", t, 2);
    endtask

    task automatic test_double();
        logic [31:0] r32; logic [1:0] f32; logic [63:0] r64; logic [1:0] f64;
        int lat;
        run_op(3'b001, 64'hBFF0000000000000, 64'h3FF0000000000000, r32, f32, r64, f64, lat);
        chk_cnt++;
        if ({r64, f64} !== {64'h1, 2'b00}) $display("FAIL dbl_flt: got r=%h nv/ill=%b want r=1 nv/ill=00", r64, f64);
        else pass_cnt++;
        run_op(3'b001, 64'h3FF0000000000000, 64'hBFF0000000000000, r32, f32, r64, f64, lat);
        chk_cnt++;
        if ({r64, f64} !== {64'h0, 2'b00}) $display("FAIL dbl_flt_rev: got r=%h nv/ill=%b want r=0 nv/ill=00", r64, f64);
        else pass_cnt++;
        run_op(3'b101, 64'h3FF0000000000000, 64'h4000000000000000, r32, f32, r64, f64, lat);
        chk_cnt++;
        if ({r64, f64} !== {64'h0, 2'b01}) $display("FAIL dbl_illegal: got r=%h nv/ill=%b want r=0 nv/ill=01", r64, f64);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] va [4];
        logic [31:0] vb [4];
        logic [1:0]  want [4];
        logic [1:0]  got [4];
        int sent = 0;
        int recv = 0;
        va[0] = 32'hBF800000; vb[0] = 32'h3F800000; want[0] = 2'b10;
        va[1] = 32'h3F800000; vb[1] = 32'hBF800000; want[1] = 2'b00;
        va[2] = 32'h7FC00000; vb[2] = 32'h3F800000; want[2] = 2'b01;
        va[3] = 32'hC0000000; vb[3] = 32'hBF800000; want[3] = 2'b10;
        op = 3'b001;
        for (int cyc = 0; cyc < 40 && recv < 4; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 5);
            if (sent < 4) begin
                in_valid = 1'b1; a32 = va[sent]; b32 = vb[sent];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (cyc == 2) begin
                chk_cnt++;
                if (in_ready32 !== 1'b0 || sent != 2) $display("FAIL b2b_full: got in_ready=%b accepts=%0d want 0/2", in_ready32, sent);
                else pass_cnt++;
            end
            if (cyc >= 2 && cyc <= 4) begin
                chk_cnt++;
                if ({out_valid32, res32, nv32} !== {1'b1, 32'h1, 1'b0}) $display("FAIL b2b_stall%0d: got v/r/nv=%b/%h/%b want 1/00000001/0", cyc, out_valid32, res32, nv32);
                else pass_cnt++;
            end
            if (cyc == 5) begin
                chk_cnt++;
                if (in_ready32 !== 1'b1) $display("FAIL b2b_passthru_ready: got %b want 1", in_ready32);
                else pass_cnt++;
            end
            if (out_valid32 && out_ready) begin
                got[recv] = {res32[0], nv32};
                $display("b2b out #%0d r=%h nv=%b", recv, res32, nv32);
                recv++;
            end
            if (in_valid && in_ready32) sent++;
        end
        in_valid = 1'b0;
        chk_cnt++;
        if (recv != 4) $display("FAIL b2b_count: got %0d want 4", recv);
        else pass_cnt++;
        for (int i = 0; i < 4 && i < recv; i++) begin
            chk_cnt++;
            if (got[i] !== want[i]) $display("FAIL b2b_order[%0d]: got %b want %b", i, got[i], want[i]);
            else pass_cnt++;
        end
        @(negedge clk); #1;
        chk_cnt++;
        if (out_valid32 !== 1'b0) $display("FAIL b2b_drain: got out_valid=%b want 0", out_valid32);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; op = 3'b001;
        a32 = 32'hBF800000; b32 = 32'h3F800000;
        @(negedge clk);
        @(negedge clk);
        op = 3'b010; a32 = 32'h3F800000; b32 = 32'h3F800000; flush = 1'b1;
        #1;
        chk_cnt++;
        if (in_ready32 !== 1'b0) $display("FAIL flush_in_ready: got %b want 0", in_ready32);
        else pass_cnt++;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk_cnt++;
        if (out_valid32 !== 1'b0) $display("FAIL flush_clear: got out_valid=%b want 0", out_valid32);
        else pass_cnt++;
        chk_cnt++;
        if (in_ready32 !== 1'b1) $display("FAIL flush_reaccept: got in_ready=%b want 1", in_ready32);
        else pass_cnt++;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk_cnt++;
        if (out_valid32 !== 1'b0) $display("FAIL flush_blocked_input: got out_valid=%b want 0", out_valid32);
        else pass_cnt++;
        @(negedge clk); #1;
        chk_cnt++;
        if ({out_valid32, res32, nv32} !== {1'b1, 32'h1, 1'b0}) $display("FAIL flush_new_result: got v/r/nv=%b/%h/%b want 1/00000001/0", out_valid32, res32, nv32);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; op = 3'b001;
        a32 = 32'hBF800000; b32 = 32'h3F800000;
        @(negedge clk);
        op = 3'b101;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk_cnt++;
        if ({out_valid32, res32} !== {1'b1, 32'h1}) $display("FAIL rstmid_before: got v/r=%b/%h want 1/00000001", out_valid32, res32);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        chk_cnt++;
        if ({out_valid32, res32, nv32, ill32} !== 35'd0) $display("FAIL rstmid_async: got %h want 0", {out_valid32, res32, nv32, ill32});
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk_cnt++;
        if ({out_valid32, ill32} !== 2'b00) $display("FAIL rstmid_no_partial: got v/ill=%b/%b want 0/0", out_valid32, ill32);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_compare();
        test_nan();
        test_minmax();
        test_illegal();
        test_double();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
